// File: rtl/outmap_compressor_pkg.sv
// rtl/outmap_compressor_pkg.sv - compressor state enum, group/word sizes and layer byte limits
// Layer limits sit beside the OFMAP size defines so they track any resize of the output map.
`ifndef OUTMAP_COMPRESSOR_DEFS
`define OUTMAP_COMPRESSOR_DEFS
`define OFMAP_MAX_W 64
`define OFMAP_MAX_H 64
`define OFMAP_MAX_C 64
`define COMP_GROUP_BYTES 8
`define COMP_OUT_BYTES 8
`define COMP_MAX_RAW_BYTES (`OFMAP_MAX_W * `OFMAP_MAX_H * `OFMAP_MAX_C)
`define COMP_MAX_ENC_BYTES (`COMP_MAX_RAW_BYTES + (`COMP_MAX_RAW_BYTES + `COMP_GROUP_BYTES - 1) / `COMP_GROUP_BYTES)
`endif

package outmap_compressor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } COMP_STATE;

endpackage

// File: rtl/outmap_compressor_if.sv
// rtl/outmap_compressor_if.sv - output-buffer window in, packed compressed words out
// The slave view belongs to the compressor; the master view to whoever drives the buffer side and sinks words.
interface outmap_compressor_if;

  logic [15:0][7:0] outmap_data;
  logic [4:0]       outmap_data_valid_num;
  logic [4:0]       valid_taken_num;
  logic             send_done;
  logic [63:0]      comp_data;
  logic             comp_valid;
  logic             comp_ready;
  logic             comp_last;
  logic             comp_idle;

  modport slave (
    input  outmap_data, outmap_data_valid_num, send_done, comp_ready,
    output valid_taken_num, comp_data, comp_valid, comp_last, comp_idle
  );

  modport master (
    output outmap_data, outmap_data_valid_num, send_done, comp_ready,
    input  valid_taken_num, comp_data, comp_valid, comp_last, comp_idle
  );

endinterface

// File: rtl/outmap_compressor_zero_mask_pack.sv
// rtl/outmap_compressor_zero_mask_pack.sv - one group to mask byte plus its non-zero bytes
// Purely combinational; bytes at or beyond num never contribute.
module zero_mask_pack #(
  parameter int GROUP_BYTES = `COMP_GROUP_BYTES,
  localparam int NW = $clog2(GROUP_BYTES + 2)
) (
  input  logic [GROUP_BYTES-1:0][7:0] data,
  input  logic [NW-1:0]               num,
  output logic [GROUP_BYTES-1:0]      mask,
  output logic [GROUP_BYTES:0][7:0]   packed_bytes,
  output logic [NW-1:0]               byte_count
);

  logic [NW-1:0] pop;

  always_comb begin
    mask         = '0;
    packed_bytes = '0;
    pop          = '0;
    for (int i = 0; i < GROUP_BYTES; i++) begin
      if (NW'(i) < num && data[i] != 8'h00) mask[i] = 1'b1;
    end
    packed_bytes[0] = 8'(mask);
    for (int i = 0; i < GROUP_BYTES; i++) begin
      if (mask[i]) begin
        pop = pop + 1'b1;
        packed_bytes[pop] = data[i];
      end
    end
    byte_count = pop + 1'b1;
  end

endmodule

// File: rtl/outmap_compressor.sv
// rtl/outmap_compressor.sv - group-mask compressor: FSM, take logic, byte accumulator, output word register
// Defining COMP_STATS_EN adds stat_raw_bytes/stat_comp_bytes layer counters.
module outmap_compressor
  import outmap_compressor_pkg::*;
#(
  parameter int GROUP_BYTES = `COMP_GROUP_BYTES,
  parameter int OUT_BYTES   = `COMP_OUT_BYTES,
  parameter int ACC_BYTES   = 32
) (
  input  logic clk,
  input  logic rst,
  outmap_compressor_if.slave bus
`ifdef COMP_STATS_EN
  ,
  output logic [31:0] stat_raw_bytes,
  output logic [31:0] stat_comp_bytes
`endif
);

  localparam int         AW         = $clog2(ACC_BYTES);
  localparam logic [5:0] TAKE_LIMIT = 6'(ACC_BYTES - GROUP_BYTES - 1);
  localparam logic [5:0] WORD_BYTES = 6'(OUT_BYTES);
  localparam logic [4:0] GROUP_MAX  = 5'(GROUP_BYTES);

  COMP_STATE state, state_next;

  logic [ACC_BYTES-1:0][7:0] acc, acc_next;
  logic [5:0]                acc_count, acc_count_next, base, pos;
  logic [63:0]               word_reg, load_word;
  logic                      word_valid, word_last;
  logic                      active, slot_free, load, load_full, load_last;
  logic [4:0]                take;
  logic [GROUP_BYTES-1:0]    grp_mask;
  logic [GROUP_BYTES:0][7:0] grp_bytes;
  logic [3:0]                grp_count;
  logic                      unused_bits;

  zero_mask_pack #(.GROUP_BYTES(GROUP_BYTES)) u_pack (
    .data         (bus.outmap_data[GROUP_BYTES-1:0]),
    .num          (take[3:0]),
    .mask         (grp_mask),
    .packed_bytes (grp_bytes),
    .byte_count   (grp_count)
  );

  assign unused_bits = ^{grp_mask, bus.outmap_data[15:GROUP_BYTES]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Taking is only allowed while a whole worst-case group still fits behind the current bytes.
  always_comb begin
    state_next = state;
    take       = '0;
    unique case (state)
      IDLE: if (bus.outmap_data_valid_num != 5'd0) state_next = RUN;
      RUN: begin
        if (acc_count <= TAKE_LIMIT)
          take = (bus.outmap_data_valid_num > GROUP_MAX) ? GROUP_MAX : bus.outmap_data_valid_num;
        if (take != 5'd0 && bus.send_done) state_next = FLUSH;
      end
      FLUSH: if (acc_count == 6'd0 && word_valid && bus.comp_ready && word_last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    active    = (state == RUN) || (state == FLUSH);
    slot_free = !word_valid || bus.comp_ready;
    load_full = acc_count >= WORD_BYTES;
    load      = active && slot_free && (load_full || (state == FLUSH && acc_count != 6'd0));
    load_last = (state == FLUSH) && (acc_count <= WORD_BYTES);
    load_word = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (6'(i) < acc_count) load_word[i*8 +: 8] = acc[i];
    end

    acc_next = acc;
    base     = acc_count;
    pos      = '0;
    if (load) begin
      for (int i = 0; i < ACC_BYTES - OUT_BYTES; i++) acc_next[i] = acc[i+OUT_BYTES];
      for (int i = ACC_BYTES - OUT_BYTES; i < ACC_BYTES; i++) acc_next[i] = 8'h00;
      base = load_full ? acc_count - WORD_BYTES : 6'd0;
    end
    // New group lands right behind whatever survives this cycle's drain.
    if (take != 5'd0) begin
      for (int j = 0; j <= GROUP_BYTES; j++) begin
        pos = base + 6'(j);
        if (4'(j) < grp_count && pos < 6'(ACC_BYTES)) acc_next[pos[AW-1:0]] = grp_bytes[j];
      end
    end
    acc_count_next = base + ((take != 5'd0) ? {2'b00, grp_count} : 6'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      acc_count  <= '0;
      word_reg   <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      acc       <= acc_next;
      acc_count <= acc_count_next;
      if (load) begin
        word_reg   <= load_word;
        word_valid <= 1'b1;
        word_last  <= load_last;
      end else if (word_valid && bus.comp_ready) begin
        word_valid <= 1'b0;
        word_last  <= 1'b0;
      end
    end
  end

  assign bus.valid_taken_num = take;
  assign bus.comp_data       = word_reg;
  assign bus.comp_valid      = word_valid;
  assign bus.comp_last       = word_last;
  assign bus.comp_idle       = (state == IDLE);

`ifdef COMP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_raw_bytes  <= '0;
      stat_comp_bytes <= '0;
    end else if (state == IDLE && state_next == RUN) begin
      stat_raw_bytes  <= '0;
      stat_comp_bytes <= '0;
    end else if (take != 5'd0) begin
      stat_raw_bytes  <= stat_raw_bytes + 32'(take);
      stat_comp_bytes <= stat_comp_bytes + 32'(grp_count);
    end
  end
`endif

endmodule

// File: tb/tb_outmap_compressor.sv
// tb/tb_outmap_compressor.sv - directed layers against a byte-stream model of the group-mask compressor
// With COMP_STATS_EN defined the statistics counters are connected and checked too.
module tb_outmap_compressor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  outmap_compressor_if bus();
`ifdef COMP_STATS_EN
  logic [31:0] stat_raw_bytes, stat_comp_bytes;
`endif

  outmap_compressor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef COMP_STATS_EN
    ,
    .stat_raw_bytes  (stat_raw_bytes),
    .stat_comp_bytes (stat_comp_bytes)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  logic [63:0] words[$];
  bit          lasts[$];
  int          takes[$];
  bit          ended, seen_last, any_last, hold_pend, hold_last;
  logic [63:0] hold_data;
  int          cyc, last_xfer_cyc, idle_cyc, probe_rem;

  task automatic chk(input bit ok, input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input int k, input logic [63:0] exp, input bit exp_last);
    if (k < words.size()) chk(words[k] === exp && lasts[k] == exp_last, name, words[k], exp);
    else chk(1'b0, name, 0, exp);
  endtask

  task automatic new_layer();
    words.delete(); lasts.delete(); takes.delete(); exp_q.delete();
    ended = 0; seen_last = 0; any_last = 0; hold_pend = 0;
    last_xfer_cyc = -1; idle_cyc = -1; cyc = 0; probe_rem = -1;
  endtask

  // One cycle: present the buffer window, then judge outputs and the take against the model.
  task automatic step(input bit ready);
    int n, vn, lim;
    logic [63:0] w;
    logic [7:0]  m;
    logic [7:0]  nz[$];
    bit          exp_last;
    @(negedge clk);
    for (int i = 0; i < 16; i++) bus.outmap_data[i] = (i < src_q.size()) ? src_q[i] : 8'h00;
    vn = (src_q.size() > 16) ? 16 : src_q.size();
    bus.outmap_data_valid_num = 5'(vn);
    bus.send_done  = (src_q.size() != 0) && (src_q.size() <= 8);
    bus.comp_ready = ready;
    #1;
    if (hold_pend)
      chk(bus.comp_valid && bus.comp_data === hold_data && bus.comp_last == hold_last,
          "hold_stable", bus.comp_data, hold_data);
    hold_pend = bus.comp_valid && !bus.comp_ready;
    hold_data = bus.comp_data;
    hold_last = bus.comp_last;
    if (bus.comp_last) begin
      any_last = 1;
      chk(bus.comp_valid, "last_without_valid", bus.comp_valid, 1);
    end
    if (bus.comp_valid && bus.comp_ready) begin
      w = '0;
      for (int j = 0; j < 8; j++) if (j < exp_q.size()) w[j*8 +: 8] = exp_q[j];
      exp_last = ended && exp_q.size() <= 8;
      chk(exp_q.size() != 0, "word_expected", exp_q.size(), 1);
      chk(bus.comp_data === w, "word_data", bus.comp_data, w);
      chk(bus.comp_last == exp_last, "word_last", bus.comp_last, exp_last);
      for (int j = 0; j < 8; j++) if (exp_q.size() != 0) void'(exp_q.pop_front());
      words.push_back(bus.comp_data);
      lasts.push_back(bus.comp_last);
      if (bus.comp_last) begin
        seen_last = 1;
        last_xfer_cyc = cyc;
      end
    end
    n   = int'(bus.valid_taken_num);
    lim = (vn > 8) ? 8 : vn;
    chk(n == 0 || n == lim, "take_amount", n, lim);
    if (bus.comp_idle) chk(n == 0, "take_in_idle", n, 0);
    if (n != 0) begin
      takes.push_back(n);
      m = 8'h00;
      nz.delete();
      for (int j = 0; j < n && j < src_q.size(); j++) begin
        if (src_q[j] != 8'h00) begin
          m[j] = 1'b1;
          nz.push_back(src_q[j]);
        end
      end
      exp_q.push_back(m);
      foreach (nz[k]) exp_q.push_back(nz[k]);
      if (bus.send_done) ended = 1;
      for (int j = 0; j < n; j++) if (src_q.size() != 0) void'(src_q.pop_front());
    end
    cyc++;
  endtask

  task automatic run_layer(input int stall, input int probe);
    while (!(seen_last && bus.comp_idle) && cyc < 300) begin
      if (cyc == probe) probe_rem = src_q.size();
      step(cyc >= stall);
    end
    chk(seen_last && bus.comp_idle, "layer_complete", cyc, 0);
    idle_cyc = cyc - 1;
  endtask

  initial begin
    rst = 1'b0;
    bus.outmap_data = '0;
    bus.outmap_data_valid_num = '0;
    bus.send_done = 1'b0;
    bus.comp_ready = 1'b0;
    #22;
    chk(bus.comp_valid == 0 && bus.comp_last == 0, "reset_valid_last", {bus.comp_valid, bus.comp_last}, 0);
    chk(bus.comp_data == 64'h0, "reset_data", bus.comp_data, 0);
    chk(bus.comp_idle == 1 && bus.valid_taken_num == 0, "reset_idle_take", bus.comp_idle, 1);
    @(negedge clk);
    rst = 1'b1;

    // Single group of five bytes.
    new_layer();
    src_q = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h33};
    run_layer(0, -1);
    chk(takes.size() == 1 && takes[0] == 5, "single_take", takes.size() ? takes[0] : 0, 5);
    chk(words.size() == 1, "single_word_count", words.size(), 1);
    chk_word("single_word", 0, 64'h0000_0000_3322_111A, 1);

    // All-zero layer of 55 bytes.
    new_layer();
    for (int i = 0; i < 55; i++) src_q.push_back(8'h00);
    run_layer(0, -1);
    chk(takes.size() == 7 && takes[0] == 8 && takes[5] == 8 && takes[6] == 7, "zero_takes", takes.size(), 7);
    chk(words.size() == 1, "zero_word_count", words.size(), 1);
    chk_word("zero_word", 0, 64'h0, 1);
`ifdef COMP_STATS_EN
    chk(stat_raw_bytes == 32'd55, "stat_raw", stat_raw_bytes, 55);
    chk(stat_comp_bytes == 32'd7, "stat_comp", stat_comp_bytes, 7);
`endif

    // Dense 16 bytes with the sink stalled for 20 cycles.
    new_layer();
    for (int i = 0; i < 16; i++) src_q.push_back(8'hA0 + 8'(i));
    run_layer(20, -1);
    chk(words.size() == 3, "dense_word_count", words.size(), 3);
    chk_word("dense_w0", 0, 64'hA6A5_A4A3_A2A1_A0FF, 0);
    chk_word("dense_w1", 1, 64'hADAC_ABAA_A9A8_FFA7, 0);
    chk_word("dense_w2", 2, 64'h0000_0000_0000_AFAE, 1);

    // Dense 48 bytes under a long stall: accumulator fills and taking stops.
    new_layer();
    for (int i = 0; i < 48; i++) src_q.push_back(8'(i + 1));
    run_layer(15, 12);
    chk(probe_rem == 16, "limit_stall_remaining", probe_rem, 16);
    chk(words.size() == 7, "limit_word_count", words.size(), 7);
    chk_word("limit_w6", 6, 64'h0000_302F_2E2D_2C2B, 1);

    // Row end with seven bytes and send_done on that take.
    new_layer();
    src_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h04};
    run_layer(0, -1);
    chk(takes.size() == 1 && takes[0] == 7, "rowend_take", takes.size() ? takes[0] : 0, 7);
    chk_word("rowend_word", 0, 64'h0000_0004_0302_0165, 1);
    chk(idle_cyc == last_xfer_cyc + 2, "rowend_done_to_idle", idle_cyc, last_xfer_cyc + 2);

    // Reset while twelve bytes sit in the accumulator and a word is pending.
    new_layer();
    for (int i = 0; i < 16; i++) src_q.push_back(8'hC0 + 8'(i));
    src_q.push_back(8'h00); src_q.push_back(8'h5A);
    for (int i = 0; i < 14; i++) src_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk(src_q.size() == 8, "prereset_remaining", src_q.size(), 8);
    chk(bus.comp_valid == 1, "prereset_pending", bus.comp_valid, 1);
    @(negedge clk);
    bus.outmap_data_valid_num = '0;
    bus.send_done = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk(bus.comp_valid == 0 && bus.comp_last == 0 && bus.comp_data == 0, "midreset_outputs", bus.comp_data, 0);
    chk(bus.comp_idle == 1, "midreset_idle", bus.comp_idle, 1);
    chk(!any_last, "midreset_no_last", any_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    src_q.delete();
    new_layer();
    src_q = '{8'h00, 8'h00, 8'h7E};
    run_layer(0, -1);
    chk(words.size() == 1, "postreset_word_count", words.size(), 1);
    chk_word("postreset_word", 0, 64'h0000_0000_0000_7E04, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
